// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, instruction format classes, writeback-hit helper.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    // Map a major opcode onto its immediate-encoding class.
    function automatic fmt_e decodeFmt(logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_R:                                 f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  f = FMT_I;
            OP_STORE:                             f = FMT_S;
            OP_BRANCH:                            f = FMT_B;
            OP_LUI, OP_AUIPC:                     f = FMT_U;
            OP_JAL:                               f = FMT_J;
            default:                              f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

    // True when a writeback lands on source register rs; x0 is hardwired and never matches.
    function automatic logic wbHit(logic en, logic [4:0] wa, logic [4:0] rs);
        return en && (wa != 5'd0) && (wa == rs);
    endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch-side and execute-side handshake bundles of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master is the fetch/execute environment, slave is the stage.
interface rv32_decode_stage_if;

    logic                 inValid;
    logic                 inReady;
    logic [31:0]          inInstr;
    logic [31:0]          inPc;

    logic                 outValid;
    logic                 outReady;
    logic [31:0]          outPc;
    logic [31:0]          outInstr;
    logic [31:0]          outRs1Val;
    logic [31:0]          outRs2Val;
    logic [31:0]          outImm;
    logic [4:0]           outRd;
    rv32i_pkg::fmt_e      outFmt;

    modport master (
        output inValid, inInstr, inPc, outReady,
        input  inReady, outValid, outPc, outInstr, outRs1Val, outRs2Val, outImm, outRd, outFmt
    );

    modport slave (
        input  inValid, inInstr, inPc, outReady,
        output inReady, outValid, outPc, outInstr, outRs1Val, outRs2Val, outImm, outRd, outFmt
    );

endinterface

// File: rtl/rv32_imm_gen.sv
// Classifies an RV32I instruction word and forms its sign-extended immediate.
// Latency: purely combinational.
// Backpressure: none.
module rv32_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_e        fmt,
    output logic [31:0] imm
);

    // Format class from the opcode, then the matching base-ISA immediate layout.
    always_comb begin
        fmt = decodeFmt(instr[6:0]);
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Decode/operand-fetch stage: drives RF read addresses, captures operands with WB forwarding, forms immediate.
// Latency: two edges from accept to outValid; one instruction per cycle sustained.
// Backpressure: slot A holds during RF read, slot B is the output register; inReady drops only when both are full and execute stalls.
module rv32_decode_stage
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rv32_decode_stage_if.slave  bus,
    input  logic                flush,
    output logic [4:0]          rdR1Addr,
    output logic [4:0]          rdR2Addr,
    input  logic [31:0]         r1In,
    input  logic [31:0]         r2In,
    input  logic                wbEn,
    input  logic [4:0]          wbAddr,
    input  logic [31:0]         wbData
);

    // Slot A: instruction whose operands are being read from the register file.
    logic        aValid;
    logic [31:0] aInstr;
    logic [31:0] aPc;

    // Slot B: registered bundle presented to execute.
    logic        bValid;
    logic [31:0] bPc;
    logic [31:0] bInstr;
    logic [31:0] bRs1Val;
    logic [31:0] bRs2Val;
    logic [31:0] bImm;
    logic [4:0]  bRd;
    fmt_e        bFmt;

    logic        advB;
    logic        advA;
    logic        offerTaken;
    logic        accept;
    fmt_e        aFmt;
    logic [31:0] aImm;
    logic [4:0]  aRs1;
    logic [4:0]  aRs2;
    logic [4:0]  bRs1;
    logic [4:0]  bRs2;
    logic [31:0] aRs1Fwd;
    logic [31:0] aRs2Fwd;

    assign advB        = !bValid || bus.outReady;
    assign advA        = aValid && advB;
    assign bus.inReady = !aValid || advB;
    assign offerTaken  = bus.inValid && bus.inReady;
    // A redirect discards the bundle offered in the same cycle.
    assign accept      = offerTaken && !flush;

    assign aRs1 = aInstr[19:15];
    assign aRs2 = aInstr[24:20];
    assign bRs1 = bInstr[19:15];
    assign bRs2 = bInstr[24:20];

    // The RF read data lags its address by one edge, so a write committing on the
    // transfer edge is not visible in r1In/r2In yet and must be bypassed here.
    assign aRs1Fwd = wbHit(wbEn, wbAddr, aRs1) ? wbData : r1In;
    assign aRs2Fwd = wbHit(wbEn, wbAddr, aRs2) ? wbData : r2In;

    rv32_imm_gen u_imm_gen (
        .instr (aInstr),
        .fmt   (aFmt),
        .imm   (aImm)
    );

    // RF addresses: new instruction when one is being taken, else re-drive the held one.
    always_comb begin
        rdR1Addr = aRs1;
        rdR2Addr = aRs2;
        if (rst) begin
            rdR1Addr = 5'd0;
            rdR2Addr = 5'd0;
        end else if (offerTaken) begin
            rdR1Addr = bus.inInstr[19:15];
            rdR2Addr = bus.inInstr[24:20];
        end
    end

    // Slot A: load on accept, empty when it moves to B with nothing behind it, clear on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            aValid <= 1'b0;
            aInstr <= 32'd0;
            aPc    <= 32'd0;
        end else if (flush) begin
            aValid <= 1'b0;
        end else if (accept) begin
            aValid <= 1'b1;
            aInstr <= bus.inInstr;
            aPc    <= bus.inPc;
        end else if (advA) begin
            aValid <= 1'b0;
        end
    end

    // Slot B: capture A with transfer-edge forwarding, or track writebacks while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bValid  <= 1'b0;
            bPc     <= 32'd0;
            bInstr  <= 32'd0;
            bRs1Val <= 32'd0;
            bRs2Val <= 32'd0;
            bImm    <= 32'd0;
            bRd     <= 5'd0;
            bFmt    <= FMT_R;
        end else begin
            if (flush) begin
                bValid <= 1'b0;
            end else if (advB) begin
                bValid <= aValid;
            end

            if (advA) begin
                bPc     <= aPc;
                bInstr  <= aInstr;
                bRs1Val <= aRs1Fwd;
                bRs2Val <= aRs2Fwd;
                bImm    <= aImm;
                bRd     <= aInstr[11:7];
                bFmt    <= aFmt;
            end else if (bValid && !bus.outReady) begin
                if (wbHit(wbEn, wbAddr, bRs1)) begin
                    bRs1Val <= wbData;
                end
                if (wbHit(wbEn, wbAddr, bRs2)) begin
                    bRs2Val <= wbData;
                end
            end
        end
    end

    assign bus.outValid  = bValid;
    assign bus.outPc     = bPc;
    assign bus.outInstr  = bInstr;
    assign bus.outRs1Val = bRs1Val;
    assign bus.outRs2Val = bRs2Val;
    assign bus.outImm    = bImm;
    assign bus.outRd     = bRd;
    assign bus.outFmt    = bFmt;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage with a registered-address register-file model.
// Latency: checks two-edge accept-to-output timing.
// Backpressure: exercises stall, hold forwarding, flush and mid-run reset.
module tb_rv32_decode_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] I_ADD    = 32'h003100B3; // add x1,x2,x3
    localparam logic [31:0] I_ADD_X0 = 32'h003000B3; // add x1,x0,x3
    localparam logic [31:0] I_SW     = 32'hFE532E23; // sw x5,-4(x6)
    localparam logic [31:0] I_LUI    = 32'h123450B7; // lui x1,0x12345
    localparam logic [31:0] I_ILL    = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  rdR1Addr;
    logic [4:0]  rdR2Addr;
    logic [31:0] r1In;
    logic [31:0] r2In;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;

    int tests;
    int fails;

    rv32_decode_stage_if bus ();

    rv32_decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .rdR1Addr (rdR1Addr),
        .rdR2Addr (rdR2Addr),
        .r1In     (r1In),
        .r2In     (r2In),
        .wbEn     (wbEn),
        .wbAddr   (wbAddr),
        .wbData   (wbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: address registered on the edge, array read combinationally.
    logic [31:0] regs [32];
    logic [4:0]  rfA1;
    logic [4:0]  rfA2;
    always @(posedge clk) begin
        rfA1 <= rdR1Addr;
        rfA2 <= rdR2Addr;
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h100 + 32'(i);
            regs[0] <= 32'd0;
            regs[2] <= 32'h11;
            regs[3] <= 32'h22;
        end else if (wbEn && wbAddr != 5'd0) begin
            regs[wbAddr] <= wbData;
        end
    end
    assign r1In = regs[rfA1];
    assign r2In = regs[rfA2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; flush = 1'b0;
        wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'd0;
        bus.inValid = 1'b0; bus.inInstr = 32'd0; bus.inPc = 32'd0; bus.outReady = 1'b1;

        // Reset
        #1;
        chk("rst_raddr1_early", 32'(rdR1Addr), 32'd0);
        tick(); tick();
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_outRs1Val", bus.outRs1Val, 32'd0);
        chk("rst_outImm", bus.outImm, 32'd0);
        chk("rst_outPc", bus.outPc, 32'd0);
        chk("rst_outFmt", 32'(bus.outFmt), 32'(FMT_R));
        chk("rst_raddr1", 32'(rdR1Addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_inReady", 32'(bus.inReady), 32'd1);

        // Basic operand fetch
        bus.inValid = 1'b1; bus.inInstr = I_ADD; bus.inPc = 32'h100;
        #1;
        chk("basic_raddr1", 32'(rdR1Addr), 32'd2);
        chk("basic_raddr2", 32'(rdR2Addr), 32'd3);
        tick();
        bus.inValid = 1'b0;
        chk("basic_valid_e0", 32'(bus.outValid), 32'd0);
        tick();
        chk("basic_valid", 32'(bus.outValid), 32'd1);
        chk("basic_rs1", bus.outRs1Val, 32'h11);
        chk("basic_rs2", bus.outRs2Val, 32'h22);
        chk("basic_rd", 32'(bus.outRd), 32'd1);
        chk("basic_fmt", 32'(bus.outFmt), 32'(FMT_R));
        chk("basic_pc", bus.outPc, 32'h100);
        chk("basic_instr", bus.outInstr, I_ADD);
        chk("basic_imm", bus.outImm, 32'd0);
        tick();
        chk("basic_drain", 32'(bus.outValid), 32'd0);

        // Transfer-edge forwarding
        bus.inValid = 1'b1; bus.inInstr = I_ADD; bus.inPc = 32'h110;
        tick();
        bus.inValid = 1'b0;
        wbEn = 1'b1; wbAddr = 5'd2; wbData = 32'hAA;
        tick();
        wbEn = 1'b0;
        chk("fwd_rs1", bus.outRs1Val, 32'hAA);
        chk("fwd_rs2", bus.outRs2Val, 32'h22);

        // Writes to x0 are never forwarded
        bus.inValid = 1'b1; bus.inInstr = I_ADD_X0; bus.inPc = 32'h120;
        tick();
        bus.inValid = 1'b0;
        wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'hFFFF;
        tick();
        wbEn = 1'b0;
        chk("x0_valid", 32'(bus.outValid), 32'd1);
        chk("x0_rs1", bus.outRs1Val, 32'd0);
        chk("x0_rs2", bus.outRs2Val, 32'h22);
        tick();

        // Backpressure with hold forwarding
        bus.outReady = 1'b0;
        bus.inValid = 1'b1; bus.inInstr = I_ADD; bus.inPc = 32'h200;
        #1;
        chk("bp_rdy0", 32'(bus.inReady), 32'd1);
        tick();
        bus.inInstr = I_SW; bus.inPc = 32'h204;
        #1;
        chk("bp_rdy1", 32'(bus.inReady), 32'd1);
        tick();
        bus.inInstr = I_LUI; bus.inPc = 32'h208;
        wbEn = 1'b1; wbAddr = 5'd3; wbData = 32'h55;
        #1;
        chk("bp_rdy2", 32'(bus.inReady), 32'd0);
        tick();
        wbEn = 1'b0;
        chk("bp_hold_pc", bus.outPc, 32'h200);
        chk("bp_hold_rs1", bus.outRs1Val, 32'hAA);
        chk("bp_hold_rs2", bus.outRs2Val, 32'h55);
        chk("bp_hold_rdy", 32'(bus.inReady), 32'd0);
        bus.outReady = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.inReady), 32'd1);
        tick();
        bus.inValid = 1'b0;
        chk("bp_2_valid", 32'(bus.outValid), 32'd1);
        chk("bp_2_pc", bus.outPc, 32'h204);
        chk("bp_2_imm", bus.outImm, 32'hFFFFFFFC);
        chk("bp_2_fmt", 32'(bus.outFmt), 32'(FMT_S));
        chk("bp_2_rs1", bus.outRs1Val, 32'h106);
        chk("bp_2_rs2", bus.outRs2Val, 32'h105);
        tick();
        chk("bp_3_valid", 32'(bus.outValid), 32'd1);
        chk("bp_3_pc", bus.outPc, 32'h208);
        chk("bp_3_imm", bus.outImm, 32'h12345000);
        chk("bp_3_fmt", 32'(bus.outFmt), 32'(FMT_U));
        chk("bp_3_rd", 32'(bus.outRd), 32'd1);
        tick();
        chk("bp_empty", 32'(bus.outValid), 32'd0);

        // Illegal opcode
        bus.inValid = 1'b1; bus.inInstr = I_ILL; bus.inPc = 32'h300;
        tick();
        bus.inValid = 1'b0;
        tick();
        chk("ill_valid", 32'(bus.outValid), 32'd1);
        chk("ill_fmt", 32'(bus.outFmt), 32'(FMT_ILLEGAL));
        chk("ill_imm", bus.outImm, 32'd0);
        chk("ill_pc", bus.outPc, 32'h300);
        tick();

        // Flush with both slots full and a bundle offered
        bus.outReady = 1'b0;
        bus.inValid = 1'b1; bus.inInstr = I_ADD; bus.inPc = 32'h400;
        tick();
        bus.inPc = 32'h404;
        tick();
        bus.outReady = 1'b1; flush = 1'b1; bus.inPc = 32'h408;
        #1;
        chk("fl_rdy", 32'(bus.inReady), 32'd1);
        chk("fl_b_pc", bus.outPc, 32'h400);
        tick();
        flush = 1'b0; bus.inValid = 1'b0;
        chk("fl_valid0", 32'(bus.outValid), 32'd0);
        tick();
        chk("fl_valid1", 32'(bus.outValid), 32'd0);
        bus.inValid = 1'b1; bus.inInstr = I_LUI; bus.inPc = 32'h500;
        tick();
        bus.inValid = 1'b0;
        tick();
        chk("fl_next_valid", 32'(bus.outValid), 32'd1);
        chk("fl_next_pc", bus.outPc, 32'h500);
        chk("fl_next_imm", bus.outImm, 32'h12345000);
        tick();
        chk("fl_next_drain", 32'(bus.outValid), 32'd0);

        // Reset in the middle of operation
        bus.inValid = 1'b1; bus.inInstr = I_SW; bus.inPc = 32'h600;
        tick();
        bus.inValid = 1'b0;
        tick();
        chk("mr_valid", 32'(bus.outValid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_raddr1", 32'(rdR1Addr), 32'd0);
        tick();
        chk("mr_outValid", 32'(bus.outValid), 32'd0);
        chk("mr_outPc", bus.outPc, 32'd0);
        chk("mr_outImm", bus.outImm, 32'd0);
        chk("mr_outInstr", bus.outInstr, 32'd0);
        chk("mr_outFmt", 32'(bus.outFmt), 32'(FMT_R));
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Instruction decode / operand-fetch stage of the RV32I core. It sits between fetch and execute and drives the register file's read addresses. The register file registers those addresses internally, so operands return one cycle later; this stage captures them with writeback forwarding. It also generates the immediate and presents a registered, valid/ready-handshaked bundle to execute.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- inValid  in  1  fetch bundle valid
- inReady  out  1  stage accepts bundle this cycle
- inInstr  in  32  instruction word
- inPc  in  32  instruction address
- flush  in  1  discard all in-flight instructions (branch/jump redirect)
- rdR1Addr  out  5  register-file read address 1 (rs1 = instr[19:15])
- rdR2Addr  out  5  register-file read address 2 (rs2 = instr[24:20])
- r1In  in  32  register-file read data 1, for the address presented on the previous edge
- r2In  in  32  register-file read data 2
- wbEn  in  1  writeback write enable (same signal as the register-file write port)
- wbAddr  in  5  writeback destination
- wbData  in  32  writeback data
- outValid  out  1  execute bundle valid
- outReady  in  1  execute accepts bundle
- outPc, outInstr  out  32  pass-through of PC and instruction
- outRs1Val, outRs2Val  out  32  forwarded operand values
- outImm  out  32  sign/zero-formed immediate
- outRd  out  5  instr[11:7]
- outFmt  out  3  fmt_e format class

## Operation
- Two internal slots:
  - A holds aValid/aInstr/aPc while the register file reads.
  - B is the output register.
- Advance conditions:
  - advB = !bValid || outReady
  - advA = aValid && advB
  - inReady = !aValid || advB
- Address drive:
  - When inValid && inReady, rdR1Addr/rdR2Addr take their fields from inInstr.
  - Otherwise they take their fields from aInstr.
  - Re-driving the held addresses keeps the register file's address register pointing at the stalled instruction.
- Forwarding on the A→B transfer:
  - If wbEn, wbAddr==rs1 and rs1!=0, outRs1Val captures wbData; otherwise it captures r1In. rs2 is handled identically.
  - This is required because r1In does not yet reflect a write that commits on the same edge.
- Hold update: while bValid && !outReady, any wbEn to a nonzero register matching B's rs1 (or rs2) overwrites outRs1Val (outRs2Val).
- Writes to x0 are never forwarded.
- Format decode on opcode instr[6:0]:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → ILLEGAL
- Immediates follow the RV32I base encodings (I, S, B, U, J), sign-extended from instr[31]. R and ILLEGAL give 0.
- Flush: at the next edge aValid=0 and bValid=0. Flush dominates; a bundle offered in the flush cycle is dropped even if inReady=1.
- Reset (and reset mid-operation) clears:
  - aValid, bValid (so outValid=0)
  - all out* data to 0
  - rdR1Addr/rdR2Addr to 0
  - outFmt to FMT_R

## Timing
- Bundle accepted at edge E0; operands are valid on r1In/r2In during the following cycle; B is loaded at edge E1 if advB.
- Outputs are valid from E1; latency is two edges, throughput one instruction per cycle.
- All outputs are registered except inReady and rdR1Addr/rdR2Addr, which are combinational.
- Stall: if outReady=0 with both slots full, inReady=0 and no state is lost. The held B data is stable except for hold-forwarding updates.
- Simultaneous events:
  - Accept into A and advance A→B in the same cycle is legal.
  - Writeback to rs1 and rs2 of the same register updates both operands.

## Structure
- Shared package rv32i_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - typedef enum logic[2:0] fmt_e {FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILLEGAL=6}
- Sub-module rv32_imm_gen: combinational (instr → fmt, imm), instantiated once, reusable by the later branch-predict logic.

## Test plan
- Reset: assert rst for 2 cycles → outValid=0, all out* = 0, rdR1Addr=0; inReady=1 in the first cycle after reset.
- Basic operands: register file holds x2=0x11, x3=0x22; send add x1,x2,x3 (0x003100B3) → two edges later outValid=1, outRs1Val=0x11, outRs2Val=0x22, outRd=1, outFmt=FMT_R.
- Transfer-edge forwarding: wbEn with x2=0xAA in the cycle A→B occurs → outRs1Val=0xAA. Same stimulus with wbAddr=0, wbData=0xFFFF and rs1=x0 → outRs1Val=0.
- Backpressure and hold forwarding: outReady=0 for 3 cycles with 3 bundles offered → inReady drops after A fills. Write x3=0x55 during the hold → outRs2Val becomes 0x55. On release, all 3 bundles emerge in order with none lost or duplicated.
- Immediates:
  - sw x5,-4(x6) (0xFE532E23) → outImm=0xFFFFFFFC, FMT_S
  - lui x1,0x12345 (0x123450B7) → outImm=0x12345000, FMT_U
  - opcode 0x7F → FMT_ILLEGAL, outImm=0
- Flush: flush high while A and B are full and a bundle is offered → next cycle outValid=0, no stale bundle emerges, next accepted instruction flows normally.
